// File: rtl/fibre_a_read_arbiter_if.sv
// Bundle between the Fibre A read arbiter, its correction-unit requesters and the Fibre A SRAM port.
// master: requesters plus memory side; slave: the arbiter.
interface fibre_a_read_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned TIMESTEPS  = 8,
  parameter int unsigned ADDR_WIDTH = 8
);
  logic [NUM_REQ-1:0]            req_read_en;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ-1:0]            req_busy;
  logic [TIMESTEPS-1:0]          req_data;
  logic [NUM_REQ-1:0]            req_valid;
  logic [ADDR_WIDTH-1:0]         mem_addr;
  logic                          mem_read_en;
  logic [TIMESTEPS-1:0]          mem_data;
  logic                          mem_valid;
  logic                          err_overflow;

  modport master (
    output req_read_en, req_addr, mem_data, mem_valid,
    input  req_busy, req_data, req_valid, mem_addr, mem_read_en, err_overflow
  );

  modport slave (
    input  req_read_en, req_addr, mem_data, mem_valid,
    output req_busy, req_data, req_valid, mem_addr, mem_read_en, err_overflow
  );
endinterface

// File: rtl/fibre_a_read_arbiter.sv
// Round-robin arbiter sharing one Fibre A read port among NUM_REQ correction units, with an in-order tag FIFO.
// Define FIBRE_ARB_COALESCE_EN to merge pending requests for the winner's address into one read.
module fibre_a_read_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned TIMESTEPS  = 8,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned MAX_OUT    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  fibre_a_read_arbiter_if.slave arb_io
);
  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned TAG_W = $clog2(MAX_OUT);
  localparam int unsigned CNT_W = TAG_W + 1;

  logic [NUM_REQ-1:0]    pend_q, pend_d;
  logic [ADDR_WIDTH-1:0] pend_addr_q [NUM_REQ];
  logic [ADDR_WIDTH-1:0] pend_addr_d [NUM_REQ];
  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic                  mem_read_en_q;
  logic [NUM_REQ-1:0]    tag_q [MAX_OUT];
  logic [TAG_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q, count_d, count_post_pop;
  logic [TIMESTEPS-1:0]  req_data_q;
  logic [NUM_REQ-1:0]    req_valid_q;
  logic                  err_q, err_d;

  logic                  pop, push, stray, drop;
  logic                  found;
  logic [PTR_W-1:0]      winner;
  logic [PTR_W:0]        cand, rr_next;
  logic [NUM_REQ-1:0]    grant;

  // A pop frees its slot in the same cycle, so fullness is judged after the pop.
  always_comb begin
    pop            = arb_io.mem_valid && (count_q != '0);
    stray          = arb_io.mem_valid && (count_q == '0);
    count_post_pop = count_q - CNT_W'(pop);
    push           = found && (count_post_pop < CNT_W'(MAX_OUT));
    count_d        = count_post_pop + CNT_W'(push);
  end

  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
      if (cand >= (PTR_W+1)'(NUM_REQ)) cand = cand - (PTR_W+1)'(NUM_REQ);
      if (!found && pend_q[cand[PTR_W-1:0]]) begin
        found  = 1'b1;
        winner = cand[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    rr_next = {1'b0, winner} + (PTR_W+1)'(1);
    if (rr_next >= (PTR_W+1)'(NUM_REQ)) rr_next = '0;
    rr_ptr_d = push ? rr_next[PTR_W-1:0] : rr_ptr_q;
  end

  always_comb begin
    grant = '0;
    if (push) begin
      grant[winner] = 1'b1;
`ifdef FIBRE_ARB_COALESCE_EN
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (pend_q[i] && (pend_addr_q[i] == pend_addr_q[winner])) grant[i] = 1'b1;
      end
`endif
    end
  end

  // A pulse on a unit being granted this cycle replaces the issued request rather than colliding with it.
  always_comb begin
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    drop        = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) pend_d[i] = 1'b0;
      if (arb_io.req_read_en[i]) begin
        if (!pend_q[i] || grant[i]) begin
          pend_d[i]      = 1'b1;
          pend_addr_d[i] = arb_io.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        end else begin
          drop = 1'b1;
        end
      end
    end
    err_d = err_q | drop | stray;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q        <= '0;
      rr_ptr_q      <= '0;
      mem_addr_q    <= '0;
      mem_read_en_q <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      req_data_q    <= '0;
      req_valid_q   <= '0;
      err_q         <= 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) pend_addr_q[i] <= '0;
      for (int unsigned j = 0; j < MAX_OUT; j++) tag_q[j] <= '0;
    end else begin
      pend_q        <= pend_d;
      pend_addr_q   <= pend_addr_d;
      rr_ptr_q      <= rr_ptr_d;
      mem_read_en_q <= push;
      count_q       <= count_d;
      err_q         <= err_d;
      req_valid_q   <= pop ? tag_q[rd_ptr_q] : '0;
      if (push) begin
        mem_addr_q      <= pend_addr_q[winner];
        tag_q[wr_ptr_q] <= grant;
        wr_ptr_q        <= wr_ptr_q + TAG_W'(1);
      end
      if (pop) begin
        req_data_q <= arb_io.mem_data;
        rd_ptr_q   <= rd_ptr_q + TAG_W'(1);
      end
    end
  end

  assign arb_io.req_busy     = pend_q;
  assign arb_io.req_data     = req_data_q;
  assign arb_io.req_valid    = req_valid_q;
  assign arb_io.mem_addr     = mem_addr_q;
  assign arb_io.mem_read_en  = mem_read_en_q;
  assign arb_io.err_overflow = err_q;
endmodule

// File: tb/tb_fibre_a_read_arbiter.sv
// Directed bench for fibre_a_read_arbiter: inputs driven 1 time unit after each rising edge,
// outputs sampled there too; the memory side is scripted step by step.
module tb_fibre_a_read_arbiter;
  logic clk;
  logic rst;
  int   total;
  int   passed;
  int   reads;
  logic [3:0] cmask [3];
  int   ncoal;

  fibre_a_read_arbiter_if #(.NUM_REQ(4), .TIMESTEPS(8), .ADDR_WIDTH(8)) bus ();

  fibre_a_read_arbiter #(
    .NUM_REQ(4), .TIMESTEPS(8), .ADDR_WIDTH(8), .MAX_OUT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .arb_io(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"},  32'(bus.req_busy),     32'h0);
    check({tag, "_data"},  32'(bus.req_data),     32'h0);
    check({tag, "_valid"}, 32'(bus.req_valid),    32'h0);
    check({tag, "_maddr"}, 32'(bus.mem_addr),     32'h0);
    check({tag, "_mren"},  32'(bus.mem_read_en),  32'h0);
    check({tag, "_err"},   32'(bus.err_overflow), 32'h0);
  endtask

  initial begin
    total = 0;
    passed = 0;
`ifdef FIBRE_ARB_COALESCE_EN
    cmask[0] = 4'b1001; cmask[1] = 4'b0010; cmask[2] = 4'b0000; ncoal = 2;
`else
    cmask[0] = 4'b1000; cmask[1] = 4'b0001; cmask[2] = 4'b0010; ncoal = 3;
`endif
    rst = 1'b1;
    bus.req_read_en = '0;
    bus.req_addr    = '0;
    bus.mem_data    = '0;
    bus.mem_valid   = 1'b0;
    tick();
    tick();
    check_reset_values("rst0");
    rst = 1'b0;

    // Round-robin, first round from rr_ptr 0, then drain in issue order.
    bus.req_addr = 32'h13121110;
    bus.req_read_en = 4'hF;
    tick();
    bus.req_read_en = '0;
    check("rr1_busy", 32'(bus.req_busy), 32'hF);
    for (int unsigned i = 0; i < 4; i++) begin
      tick();
      check("rr1_mren", 32'(bus.mem_read_en), 32'h1);
      check("rr1_addr", 32'(bus.mem_addr), 32'(16 + i));
    end
    bus.mem_valid = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      bus.mem_data = 8'(8'hD0 + i);
      tick();
      check("rr1_rvalid", 32'(bus.req_valid), 32'(1) << i);
      check("rr1_rdata", 32'(bus.req_data), 32'(8'hD0 + i));
    end
    bus.mem_valid = 1'b0;

    // Second round restarts at unit 0; nothing returned so the FIFO ends full.
    bus.req_addr = 32'h23222120;
    bus.req_read_en = 4'hF;
    tick();
    bus.req_read_en = '0;
    check("rr2_busy", 32'(bus.req_busy), 32'hF);
    for (int unsigned i = 0; i < 4; i++) begin
      tick();
      check("rr2_mren", 32'(bus.mem_read_en), 32'h1);
      check("rr2_addr", 32'(bus.mem_addr), 32'(32 + i));
    end

    // Backpressure and overflow: units 1 and 3 blocked, unit 1 pulses again.
    bus.req_addr = 32'h33003100;
    bus.req_read_en = 4'b1010;
    tick();
    bus.req_read_en = '0;
    check("bp_mren0", 32'(bus.mem_read_en), 32'h0);
    check("bp_busy0", 32'(bus.req_busy), 32'hA);
    check("bp_err0", 32'(bus.err_overflow), 32'h0);
    bus.req_addr = 32'h00003500;
    bus.req_read_en = 4'b0010;
    tick();
    bus.req_read_en = '0;
    check("bp_mren1", 32'(bus.mem_read_en), 32'h0);
    check("ovf_err1", 32'(bus.err_overflow), 32'h1);
    tick();
    check("bp_mren2", 32'(bus.mem_read_en), 32'h0);
    check("ovf_err2", 32'(bus.err_overflow), 32'h1);
    check("bp_busy2", 32'(bus.req_busy), 32'hA);
    bus.mem_data = 8'hB0;
    bus.mem_valid = 1'b1;
    tick();
    bus.mem_valid = 1'b0;
    check("bp_mren3", 32'(bus.mem_read_en), 32'h1);
    check("ovf_addr", 32'(bus.mem_addr), 32'h31);
    check("bp_rvalid", 32'(bus.req_valid), 32'h1);
    check("bp_rdata", 32'(bus.req_data), 32'hB0);
    check("bp_busy3", 32'(bus.req_busy), 32'h8);
    tick();
    check("bp_mren4", 32'(bus.mem_read_en), 32'h0);
    check("bp_busy4", 32'(bus.req_busy), 32'h8);
    check("ovf_err3", 32'(bus.err_overflow), 32'h1);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_values("rst1");

    // Single request from unit 2, 1-cycle memory.
    bus.req_addr = 32'h00150000;
    bus.req_read_en = 4'b0100;
    tick();
    bus.req_read_en = '0;
    check("one_busy", 32'(bus.req_busy), 32'h4);
    check("one_mren_t1", 32'(bus.mem_read_en), 32'h0);
    tick();
    check("one_mren_t2", 32'(bus.mem_read_en), 32'h1);
    check("one_addr", 32'(bus.mem_addr), 32'h15);
    check("one_busy_t2", 32'(bus.req_busy), 32'h0);
    tick();
    check("one_mren_t3", 32'(bus.mem_read_en), 32'h0);
    bus.mem_data = 8'hA5;
    bus.mem_valid = 1'b1;
    tick();
    bus.mem_valid = 1'b0;
    check("one_rvalid", 32'(bus.req_valid), 32'h4);
    check("one_rdata", 32'(bus.req_data), 32'hA5);
    tick();
    check("one_rvalid_end", 32'(bus.req_valid), 32'h0);
    check("one_rdata_hold", 32'(bus.req_data), 32'hA5);
    check("one_err", 32'(bus.err_overflow), 32'h0);

    // Coalescing: units 0 and 3 share 0x40, unit 1 reads 0x41.
    bus.req_addr = 32'h40004140;
    bus.req_read_en = 4'b1011;
    tick();
    bus.req_read_en = '0;
    check("co_busy", 32'(bus.req_busy), 32'hB);
    reads = 0;
    for (int unsigned c = 0; c < 4; c++) begin
      tick();
      if (bus.mem_read_en) reads++;
    end
    check("co_reads", 32'(reads), 32'(ncoal));
    bus.mem_valid = 1'b1;
    for (int k = 0; k < ncoal; k++) begin
      bus.mem_data = 8'(8'h70 + k);
      tick();
      check("co_rvalid", 32'(bus.req_valid), 32'(cmask[k]));
      check("co_rdata", 32'(bus.req_data), 32'(8'h70 + k));
    end
    bus.mem_valid = 1'b0;
    tick();
    check("co_rvalid_end", 32'(bus.req_valid), 32'h0);
    check("co_err", 32'(bus.err_overflow), 32'h0);

    // Reset with two reads outstanding, then a late return.
    bus.req_addr = 32'h00005150;
    bus.req_read_en = 4'b0011;
    tick();
    bus.req_read_en = '0;
    tick();
    check("mid_mren_a", 32'(bus.mem_read_en), 32'h1);
    tick();
    check("mid_mren_b", 32'(bus.mem_read_en), 32'h1);
    rst = 1'b1;
    #1;
    check_reset_values("rst_async");
    tick();
    rst = 1'b0;
    bus.mem_data = 8'h99;
    bus.mem_valid = 1'b1;
    tick();
    bus.mem_valid = 1'b0;
    check("late_rvalid", 32'(bus.req_valid), 32'h0);
    check("late_rdata", 32'(bus.req_data), 32'h0);
    check("late_err", 32'(bus.err_overflow), 32'h1);
    tick();
    check("late_err_sticky", 32'(bus.err_overflow), 32'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
